// File: rtl/pipe_link_model.sv
// pipe_link_model: back-to-back PIPE PHY pair for simulation (data latency, elecidle, rx detect, powerdown/phystatus).
// Define PIPE_LINK_MODEL_ERRINJ_EN to add the err_inj port that corrupts side B tx symbol 0 per lane.

module pipe_link_lane #(
  parameter int BYTES   = 1,
  parameter int LAT     = 4,
  parameter int PD_LAT  = 8,
  parameter int DET_LAT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_lane_conn,
  input  logic [8*BYTES-1:0]   i_ptx_data,
  input  logic [BYTES-1:0]     i_ptx_datak,
  input  logic                 i_ptx_elecidle,
  input  logic [1:0]           i_ppowerdown,
  input  logic                 i_err_inj,
  input  logic                 i_txdetectrx,
  input  logic [1:0]           i_powerdown,
  output logic [8*BYTES-1:0]   o_rxdata,
  output logic [BYTES-1:0]     o_rxdatak,
  output logic                 o_rxvalid,
  output logic                 o_rxelecidle,
  output logic [2:0]           o_rxstatus,
  output logic                 o_phystatus
);
  localparam int W    = 8*BYTES;
  localparam int MAXL = (PD_LAT > DET_LAT) ? PD_LAT : DET_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic [2:0] {ST_RESET, ST_IDLE, ST_PD_WAIT, ST_DET_WAIT, ST_STATUS} state_t;

  logic [W-1:0]     r_data_p  [LAT];
  logic [BYTES-1:0] r_datak_p [LAT];
  logic [LAT-1:0]   r_eidle_p;
  logic [LAT-1:0]   r_err_p;
  logic [1:0]       r_pd;
  logic [1:0]       r_ppd;
  logic             r_det_prev;
  logic             r_init;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_status;
  state_t           r_state;
  logic [W-1:0]     w_err_mask;
  logic             w_pd_chg;
  logic             w_det_req;
  logic             w_link_up;

  always_comb begin
    w_err_mask    = '0;
    w_err_mask[0] = i_err_inj;
  end

  // partner tx -> local rx delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_data_p[i]  <= '0;
        r_datak_p[i] <= '0;
      end
      r_eidle_p <= '1;
      r_err_p   <= '0;
    end else begin
      r_data_p[0]  <= i_ptx_data ^ w_err_mask;
      r_datak_p[0] <= i_ptx_datak;
      r_eidle_p[0] <= i_ptx_elecidle;
      r_err_p[0]   <= i_err_inj;
      for (int i = 1; i < LAT; i++) begin
        r_data_p[i]  <= r_data_p[i-1];
        r_datak_p[i] <= r_datak_p[i-1];
        r_eidle_p[i] <= r_eidle_p[i-1];
        r_err_p[i]   <= r_err_p[i-1];
      end
    end
  end

  // Power state gating uses the registered powerdown, bypassing the delay line.
  assign w_link_up    = !r_eidle_p[LAT-1] && (r_pd == 2'b00) && (r_ppd == 2'b00) && i_lane_conn;
  assign o_rxvalid    = w_link_up;
  assign o_rxdata     = w_link_up ? r_data_p[LAT-1]  : '0;
  assign o_rxdatak    = w_link_up ? r_datak_p[LAT-1] : '0;
  assign o_rxelecidle = r_eidle_p[LAT-1] || (r_ppd != 2'b00) || !i_lane_conn;
  assign o_rxstatus   = (r_state == ST_STATUS) ? r_status :
                        ((w_link_up && r_err_p[LAT-1]) ? 3'b100 : 3'b000);

  assign w_pd_chg  = (i_powerdown != r_pd);
  assign w_det_req = i_txdetectrx && !r_det_prev && (i_powerdown == 2'b10);

  // control FSM; phystatus is held high from reset until the first STATUS completes
  always_ff @(posedge clk) begin
    r_pd       <= i_powerdown;
    r_ppd      <= i_ppowerdown;
    r_det_prev <= i_txdetectrx;
    if (rst) begin
      r_state     <= ST_RESET;
      r_cnt       <= '0;
      r_status    <= 3'b000;
      r_init      <= 1'b1;
      o_phystatus <= 1'b1;
    end else begin
      r_status    <= 3'b000;
      o_phystatus <= 1'b0;
      case (r_state)
        ST_RESET: begin
          r_state     <= ST_PD_WAIT;
          r_cnt       <= CW'(PD_LAT);
          o_phystatus <= 1'b1;
        end
        ST_IDLE: begin
          if (w_pd_chg) begin
            r_state <= ST_PD_WAIT;
            r_cnt   <= CW'(PD_LAT);
          end else if (w_det_req) begin
            r_state <= ST_DET_WAIT;
            r_cnt   <= CW'(DET_LAT);
          end
        end
        ST_PD_WAIT: begin
          o_phystatus <= r_init;
          if (w_pd_chg) begin
            r_cnt <= CW'(PD_LAT);
          end else if (r_cnt == CW'(1)) begin
            r_state     <= ST_STATUS;
            o_phystatus <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DET_WAIT: begin
          if (w_pd_chg) begin
            r_state <= ST_PD_WAIT;
            r_cnt   <= CW'(PD_LAT);
          end else if (r_cnt == CW'(1)) begin
            r_state     <= ST_STATUS;
            o_phystatus <= 1'b1;
            r_status    <= i_lane_conn ? 3'b011 : 3'b000;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_STATUS: begin
          r_init <= 1'b0;
          if (w_pd_chg) begin
            r_state <= ST_PD_WAIT;
            r_cnt   <= CW'(PD_LAT);
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_RESET;
      endcase
    end
  end
endmodule

module pipe_link_model #(
  parameter int LANES   = 1,
  parameter int BYTES   = 1,
  parameter int LAT     = 4,
  parameter int PD_LAT  = 8,
  parameter int DET_LAT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES-1:0]         lane_conn,
`ifdef PIPE_LINK_MODEL_ERRINJ_EN
  input  logic [LANES-1:0]         err_inj,
`endif
  input  logic [LANES*8*BYTES-1:0] a_txdata,
  input  logic [LANES*BYTES-1:0]   a_txdatak,
  input  logic [LANES-1:0]         a_txelecidle,
  input  logic [LANES-1:0]         a_txdetectrx,
  input  logic [2*LANES-1:0]       a_powerdown,
  output logic [LANES*8*BYTES-1:0] a_rxdata,
  output logic [LANES*BYTES-1:0]   a_rxdatak,
  output logic [LANES-1:0]         a_rxvalid,
  output logic [LANES-1:0]         a_rxelecidle,
  output logic [3*LANES-1:0]       a_rxstatus,
  output logic [LANES-1:0]         a_phystatus,
  input  logic [LANES*8*BYTES-1:0] b_txdata,
  input  logic [LANES*BYTES-1:0]   b_txdatak,
  input  logic [LANES-1:0]         b_txelecidle,
  input  logic [LANES-1:0]         b_txdetectrx,
  input  logic [2*LANES-1:0]       b_powerdown,
  output logic [LANES*8*BYTES-1:0] b_rxdata,
  output logic [LANES*BYTES-1:0]   b_rxdatak,
  output logic [LANES-1:0]         b_rxvalid,
  output logic [LANES-1:0]         b_rxelecidle,
  output logic [3*LANES-1:0]       b_rxstatus,
  output logic [LANES-1:0]         b_phystatus
);
  localparam int W = 8*BYTES;

  logic [LANES-1:0] w_err_b;

`ifdef PIPE_LINK_MODEL_ERRINJ_EN
  assign w_err_b = err_inj;
`else
  assign w_err_b = '0;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // side A receives what side B transmits (and carries B's injected errors)
    pipe_link_lane #(.BYTES(BYTES), .LAT(LAT), .PD_LAT(PD_LAT), .DET_LAT(DET_LAT)) u_side_a (
      .clk(clk), .rst(rst), .i_lane_conn(lane_conn[l]),
      .i_ptx_data(b_txdata[l*W +: W]), .i_ptx_datak(b_txdatak[l*BYTES +: BYTES]),
      .i_ptx_elecidle(b_txelecidle[l]), .i_ppowerdown(b_powerdown[2*l +: 2]),
      .i_err_inj(w_err_b[l]),
      .i_txdetectrx(a_txdetectrx[l]), .i_powerdown(a_powerdown[2*l +: 2]),
      .o_rxdata(a_rxdata[l*W +: W]), .o_rxdatak(a_rxdatak[l*BYTES +: BYTES]),
      .o_rxvalid(a_rxvalid[l]), .o_rxelecidle(a_rxelecidle[l]),
      .o_rxstatus(a_rxstatus[3*l +: 3]), .o_phystatus(a_phystatus[l])
    );
    pipe_link_lane #(.BYTES(BYTES), .LAT(LAT), .PD_LAT(PD_LAT), .DET_LAT(DET_LAT)) u_side_b (
      .clk(clk), .rst(rst), .i_lane_conn(lane_conn[l]),
      .i_ptx_data(a_txdata[l*W +: W]), .i_ptx_datak(a_txdatak[l*BYTES +: BYTES]),
      .i_ptx_elecidle(a_txelecidle[l]), .i_ppowerdown(a_powerdown[2*l +: 2]),
      .i_err_inj(1'b0),
      .i_txdetectrx(b_txdetectrx[l]), .i_powerdown(b_powerdown[2*l +: 2]),
      .o_rxdata(b_rxdata[l*W +: W]), .o_rxdatak(b_rxdatak[l*BYTES +: BYTES]),
      .o_rxvalid(b_rxvalid[l]), .o_rxelecidle(b_rxelecidle[l]),
      .o_rxstatus(b_rxstatus[3*l +: 3]), .o_phystatus(b_phystatus[l])
    );
  end
endmodule

// File: tb/tb_pipe_link_model.sv
// Directed bench for pipe_link_model: reset, data latency, detect, powerdown, abort and optional error injection.
// Inputs change and outputs are sampled on the falling edge; n steps after a change = cycle t+n-1.

module tb_pipe_link_model;
  localparam int LANES   = 4;
  localparam int BYTES   = 2;
  localparam int W       = 8*BYTES;
  localparam int LAT     = 4;
  localparam int PD_LAT  = 8;
  localparam int DET_LAT = 16;

  logic clk = 1'b0;
  logic rst;
  logic [LANES-1:0]       lane_conn;
  logic [LANES-1:0]       err_inj;
  logic [LANES*W-1:0]     a_txdata, b_txdata, a_rxdata, b_rxdata;
  logic [LANES*BYTES-1:0] a_txdatak, b_txdatak, a_rxdatak, b_rxdatak;
  logic [LANES-1:0]       a_txelecidle, b_txelecidle, a_txdetectrx, b_txdetectrx;
  logic [2*LANES-1:0]     a_powerdown, b_powerdown;
  logic [LANES-1:0]       a_rxvalid, b_rxvalid, a_rxelecidle, b_rxelecidle;
  logic [3*LANES-1:0]     a_rxstatus, b_rxstatus;
  logic [LANES-1:0]       a_phystatus, b_phystatus;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_link_model #(.LANES(LANES), .BYTES(BYTES), .LAT(LAT), .PD_LAT(PD_LAT), .DET_LAT(DET_LAT)) dut (
    .clk(clk), .rst(rst), .lane_conn(lane_conn),
`ifdef PIPE_LINK_MODEL_ERRINJ_EN
    .err_inj(err_inj),
`endif
    .a_txdata(a_txdata), .a_txdatak(a_txdatak), .a_txelecidle(a_txelecidle),
    .a_txdetectrx(a_txdetectrx), .a_powerdown(a_powerdown),
    .a_rxdata(a_rxdata), .a_rxdatak(a_rxdatak), .a_rxvalid(a_rxvalid),
    .a_rxelecidle(a_rxelecidle), .a_rxstatus(a_rxstatus), .a_phystatus(a_phystatus),
    .b_txdata(b_txdata), .b_txdatak(b_txdatak), .b_txelecidle(b_txelecidle),
    .b_txdetectrx(b_txdetectrx), .b_powerdown(b_powerdown),
    .b_rxdata(b_rxdata), .b_rxdatak(b_rxdatak), .b_rxvalid(b_rxvalid),
    .b_rxelecidle(b_rxelecidle), .b_rxstatus(b_rxstatus), .b_phystatus(b_phystatus)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++; if (a_phystatus !== 4'hF) begin bad++; $display("FAIL rst_phy_a got %h want f", a_phystatus); end
    total++; if (b_phystatus !== 4'hF) begin bad++; $display("FAIL rst_phy_b got %h want f", b_phystatus); end
    total++; if (a_rxelecidle !== 4'hF || b_rxelecidle !== 4'hF) begin bad++; $display("FAIL rst_eidle got %h/%h want f/f", a_rxelecidle, b_rxelecidle); end
    total++; if (a_rxvalid !== 4'h0 || b_rxvalid !== 4'h0) begin bad++; $display("FAIL rst_valid got %h/%h want 0/0", a_rxvalid, b_rxvalid); end
    total++; if (a_rxdata !== '0 || b_rxdatak !== '0) begin bad++; $display("FAIL rst_data got %h/%h want 0/0", a_rxdata, b_rxdatak); end
    total++; if (a_rxstatus !== '0 || b_rxstatus !== '0) begin bad++; $display("FAIL rst_status got %h/%h want 0/0", a_rxstatus, b_rxstatus); end
    rst = 1'b0;
    // high in the release cycle and PD_LAT cycles after it, then low
    for (int i = 0; i <= PD_LAT + 1; i++) begin
      step();
      total++;
      if (a_phystatus !== ((i <= PD_LAT) ? 4'hF : 4'h0) || b_phystatus !== ((i <= PD_LAT) ? 4'hF : 4'h0)) begin
        bad++; $display("FAIL rel_phy cycle %0d got %h/%h", i, a_phystatus, b_phystatus);
      end
      total++;
      if (a_rxelecidle !== 4'hF || a_rxvalid !== 4'h0) begin
        bad++; $display("FAIL rel_eidle cycle %0d got eidle %h valid %h want f/0", i, a_rxelecidle, a_rxvalid);
      end
    end
  endtask

  task automatic test_data();
    a_txelecidle = '0;
    b_txelecidle = '0;
    repeat (LAT + 1) step();
    total++; if (a_rxvalid !== 4'hF || b_rxvalid !== 4'hF) begin bad++; $display("FAIL up_valid got %h/%h want f/f", a_rxvalid, b_rxvalid); end
    total++; if (a_rxelecidle !== 4'h0 || b_rxelecidle !== 4'h0) begin bad++; $display("FAIL up_eidle got %h/%h want 0/0", a_rxelecidle, b_rxelecidle); end
    a_txdata[2*W +: W]         = 16'hBC1C;
    a_txdatak[2*BYTES +: BYTES] = 2'b01;
    b_txdata[1*W +: W]         = 16'h5A5A;
    b_txdatak[1*BYTES +: BYTES] = 2'b10;
    for (int n = 1; n <= LAT + 1; n++) begin
      step();
      if (n == 1) begin
        a_txdata = '0; a_txdatak = '0; b_txdata = '0; b_txdatak = '0;
      end
      if (n == LAT - 1) begin
        total++; if (b_rxdata[2*W +: W] !== 16'h0000) begin bad++; $display("FAIL early_data got %h want 0000", b_rxdata[2*W +: W]); end
      end
      if (n == LAT) begin
        total++; if (b_rxdata[2*W +: W] !== 16'hBC1C) begin bad++; $display("FAIL b_data got %h want bc1c", b_rxdata[2*W +: W]); end
        total++; if (b_rxdatak[2*BYTES +: BYTES] !== 2'b01) begin bad++; $display("FAIL b_datak got %b want 01", b_rxdatak[2*BYTES +: BYTES]); end
        total++; if (b_rxvalid[2] !== 1'b1) begin bad++; $display("FAIL b_valid got %b want 1", b_rxvalid[2]); end
        total++; if (a_rxdata[1*W +: W] !== 16'h5A5A || a_rxdatak[1*BYTES +: BYTES] !== 2'b10) begin
          bad++; $display("FAIL a_data got %h/%b want 5a5a/10", a_rxdata[1*W +: W], a_rxdatak[1*BYTES +: BYTES]); end
        total++; if (a_rxstatus !== '0 || b_rxstatus !== '0) begin bad++; $display("FAIL data_status got %h/%h want 0/0", a_rxstatus, b_rxstatus); end
      end
      if (n == LAT + 1) begin
        total++; if (b_rxdata !== '0) begin bad++; $display("FAIL late_data got %h want 0", b_rxdata); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    for (int i = 0; i < 10; i++) begin
      a_txdata[0 +: W] = (i < 6) ? W'(16'hA000 + i) : '0;
      step();
      if (i >= LAT - 1) begin
        exp = (i - (LAT - 1) < 6) ? W'(16'hA000 + i - (LAT - 1)) : '0;
        total++;
        if (b_rxdata[0 +: W] !== exp) begin bad++; $display("FAIL b2b step %0d got %h want %h", i, b_rxdata[0 +: W], exp); end
      end
    end
    a_txdata = '0;
  endtask

`ifdef PIPE_LINK_MODEL_ERRINJ_EN
  task automatic test_errinj();
    b_txdata[1*W +: W] = 16'h004A;
    err_inj[1] = 1'b1;
    for (int n = 1; n <= LAT + 1; n++) begin
      step();
      if (n == 1) begin b_txdata = '0; err_inj = '0; end
      if (n == LAT - 1 || n == LAT + 1) begin
        total++; if (a_rxstatus[3*1 +: 3] !== 3'b000) begin bad++; $display("FAIL err_quiet step %0d got %b want 000", n, a_rxstatus[3*1 +: 3]); end
      end
      if (n == LAT) begin
        total++; if (a_rxdata[1*W +: W] !== 16'h004B) begin bad++; $display("FAIL err_data got %h want 004b", a_rxdata[1*W +: W]); end
        total++; if (a_rxstatus[3*1 +: 3] !== 3'b100) begin bad++; $display("FAIL err_status got %b want 100", a_rxstatus[3*1 +: 3]); end
      end
    end
  endtask
`endif

  task automatic test_detect();
    int cnt, pos;
    logic [2:0] st;
    logic other;
    // move lane 0 of side A to P1 and collect its powerdown pulse
    a_powerdown[1:0] = 2'b10;
    cnt = 0; pos = 0; st = 3'b111; other = 1'b0;
    for (int n = 1; n <= PD_LAT + 3; n++) begin
      step();
      if (a_phystatus[0]) begin cnt++; pos = n; st = a_rxstatus[2:0]; end
      other |= |a_phystatus[3:1];
    end
    total++; if (cnt !== 1 || pos !== PD_LAT + 1) begin bad++; $display("FAIL p1_pulse got cnt %0d pos %0d want 1/%0d", cnt, pos, PD_LAT + 1); end
    total++; if (st !== 3'b000) begin bad++; $display("FAIL p1_status got %b want 000", st); end
    total++; if (other !== 1'b0) begin bad++; $display("FAIL p1_other got %b want 0", other); end
    // detect with far end present
    a_txdetectrx[0] = 1'b1;
    cnt = 0; pos = 0; st = 3'b111;
    for (int n = 1; n <= DET_LAT + 4; n++) begin
      step();
      if (n == 2) a_txdetectrx[0] = 1'b0;
      if (a_phystatus[0]) begin cnt++; pos = n; st = a_rxstatus[2:0]; end
    end
    total++; if (cnt !== 1 || pos !== DET_LAT + 1) begin bad++; $display("FAIL det_pulse got cnt %0d pos %0d want 1/%0d", cnt, pos, DET_LAT + 1); end
    total++; if (st !== 3'b011) begin bad++; $display("FAIL det_status got %b want 011", st); end
    // far end absent, request held high: one result only
    lane_conn[0] = 1'b0;
    a_txdetectrx[0] = 1'b1;
    cnt = 0; pos = 0; st = 3'b111;
    for (int n = 1; n <= 2*DET_LAT + 4; n++) begin
      step();
      if (a_phystatus[0]) begin cnt++; pos = n; st = a_rxstatus[2:0]; end
    end
    total++; if (cnt !== 1 || pos !== DET_LAT + 1) begin bad++; $display("FAIL nodet_pulse got cnt %0d pos %0d want 1/%0d", cnt, pos, DET_LAT + 1); end
    total++; if (st !== 3'b000) begin bad++; $display("FAIL nodet_status got %b want 000", st); end
    a_txdetectrx[0] = 1'b0;
    lane_conn[0] = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_detect_ignored();
    logic seen;
    seen = 1'b0;
    b_txdetectrx[3] = 1'b1;
    for (int n = 1; n <= DET_LAT + 4; n++) begin
      step();
      if (n == 1) b_txdetectrx[3] = 1'b0;
      seen |= |b_phystatus;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL det_in_p0 got pulse %b want 0", seen); end
  endtask

  task automatic test_pd();
    int cnt, pos;
    total++; if (a_rxvalid[1] !== 1'b1) begin bad++; $display("FAIL pd_pre_valid got %b want 1", a_rxvalid[1]); end
    b_powerdown[3:2] = 2'b01;
    cnt = 0; pos = 0;
    for (int n = 1; n <= 16; n++) begin
      step();
      if (n == 1) begin
        total++; if (a_rxvalid[1] !== 1'b0 || b_rxvalid[1] !== 1'b0) begin bad++; $display("FAIL pd_valid got %b/%b want 0/0", a_rxvalid[1], b_rxvalid[1]); end
        total++; if (a_rxelecidle[1] !== 1'b1) begin bad++; $display("FAIL pd_eidle got %b want 1", a_rxelecidle[1]); end
      end
      if (n == 3) b_powerdown[3:2] = 2'b10;
      if (b_phystatus[1]) begin cnt++; pos = n; end
    end
    total++; if (cnt !== 1 || pos !== 12) begin bad++; $display("FAIL pd_pulse got cnt %0d pos %0d want 1/12", cnt, pos); end
  endtask

  task automatic test_det_abort();
    int cnt, pos;
    logic [2:0] st;
    a_txdetectrx[0] = 1'b1;
    cnt = 0; pos = 0; st = 3'b111;
    for (int n = 1; n <= DET_LAT + 8; n++) begin
      step();
      if (n == 1) a_txdetectrx[0] = 1'b0;
      if (n == 5) a_powerdown[1:0] = 2'b00;
      if (a_phystatus[0]) begin cnt++; pos = n; st = a_rxstatus[2:0]; end
    end
    total++; if (cnt !== 1 || pos !== 5 + PD_LAT + 1) begin bad++; $display("FAIL abort_pulse got cnt %0d pos %0d want 1/%0d", cnt, pos, 5 + PD_LAT + 1); end
    total++; if (st !== 3'b000) begin bad++; $display("FAIL abort_status got %b want 000", st); end
  endtask

  initial begin
    rst = 1'b1;
    lane_conn = '1;
    err_inj = '0;
    a_txdata = '0; a_txdatak = '0; a_txelecidle = '1; a_txdetectrx = '0; a_powerdown = '0;
    b_txdata = '0; b_txdatak = '0; b_txelecidle = '1; b_txdetectrx = '0; b_powerdown = '0;
    test_reset();
    test_data();
    test_back_to_back();
`ifdef PIPE_LINK_MODEL_ERRINJ_EN
    test_errinj();
`endif
    test_detect();
    test_detect_ignored();
    test_pd();
    test_det_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
